// File: rtl/rv32i_imm_gen.sv
// Registered RV32I immediate generator for the decode stage.
// It classifies each accepted instruction by opcode into one of the base formats
// (R/none, I, S, B, U, J). It produces the sign-extended immediate, a format code
// and an illegal-opcode flag, one cycle after acceptance.
module rv32i_imm_gen #(
  parameter int XLEN       = 32,
  parameter int ZEXT_SHAMT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic            imm_valid,
  output logic [2:0]      imm_fmt,
  output logic            imm_illegal
);

  // Format codes presented on imm_fmt
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  // RV32I base opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  // Shift encodings within OP-IMM (funct3)
  localparam logic [2:0] F3_SLLI     = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        sign;
  logic        is_shift;

  // Candidate immediates for every format, all built from the raw word
  logic [31:0] imm_i;
  logic [31:0] imm_shamt;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic [31:0] imm_next;
  logic [2:0]  fmt_next;
  logic        illegal_next;

  logic [31:0] imm_reg;
  logic        valid_reg;
  logic [2:0]  fmt_reg;
  logic        illegal_reg;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign sign   = instr[31];

  // Only OP-IMM carries a shift amount in the immediate field; other opcodes
  // with funct3 001/101 (e.g. LOAD LH/LHU) must keep plain I-type extension.
  assign is_shift = (ZEXT_SHAMT != 0) && (opcode == OP_OP_IMM) &&
                    ((funct3 == F3_SLLI) || (funct3 == F3_SRLI_SRAI));

  assign imm_i     = {{20{sign}}, instr[31:20]};
  assign imm_shamt = {27'b0, instr[24:20]};
  assign imm_s     = {{20{sign}}, instr[31:25], instr[11:7]};
  assign imm_b     = {{19{sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u     = {instr[31:12], 12'b0};
  assign imm_j     = {{11{sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Opcode-only decode: select format, immediate and illegal flag
  always_comb begin
    imm_next     = 32'b0;
    fmt_next     = FMT_NONE;
    illegal_next = 1'b0;
    unique case (opcode)
      OP_OP_IMM: begin
        fmt_next = FMT_I;
        imm_next = is_shift ? imm_shamt : imm_i;
      end
      OP_LOAD, OP_JALR, OP_MISC_MEM, OP_SYSTEM: begin
        fmt_next = FMT_I;
        imm_next = imm_i;
      end
      OP_STORE: begin
        fmt_next = FMT_S;
        imm_next = imm_s;
      end
      OP_BRANCH: begin
        fmt_next = FMT_B;
        imm_next = imm_b;
      end
      OP_LUI, OP_AUIPC: begin
        fmt_next = FMT_U;
        imm_next = imm_u;
      end
      OP_JAL: begin
        fmt_next = FMT_J;
        imm_next = imm_j;
      end
      OP_OP: begin
        fmt_next = FMT_NONE;
        imm_next = 32'b0;
      end
      default: begin
        // Includes every word whose low two bits are not 2'b11 (compressed space)
        illegal_next = 1'b1;
      end
    endcase
  end

  // Output registers: reset wins; results load only on accepted instructions,
  // otherwise the last result holds and only the valid strobe drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      imm_reg     <= 32'b0;
      valid_reg   <= 1'b0;
      fmt_reg     <= FMT_NONE;
      illegal_reg <= 1'b0;
    end else begin
      valid_reg <= instr_valid;
      if (instr_valid) begin
        imm_reg     <= imm_next;
        fmt_reg     <= fmt_next;
        illegal_reg <= illegal_next;
      end
    end
  end

  assign imm         = imm_reg[XLEN-1:0];
  assign imm_valid   = valid_reg;
  assign imm_fmt     = fmt_reg;
  assign imm_illegal = illegal_reg;

endmodule

// File: tb/tb_rv32i_imm_gen.sv
// Directed testbench for rv32i_imm_gen: hand-computed vectors for every format,
// sign/shift extremes, illegal opcodes, valid gaps and reset mid-stream.
// A second instance with ZEXT_SHAMT=0 covers the plain sign-extended shift case.
module tb_rv32i_imm_gen;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;

  logic [31:0] imm;
  logic        imm_valid;
  logic [2:0]  imm_fmt;
  logic        imm_illegal;

  logic [31:0] imm_nz;
  logic        imm_valid_nz;
  logic [2:0]  imm_fmt_nz;
  logic        imm_illegal_nz;

  int tests_run;
  int tests_failed;

  rv32i_imm_gen #(.XLEN(32), .ZEXT_SHAMT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .imm         (imm),
    .imm_valid   (imm_valid),
    .imm_fmt     (imm_fmt),
    .imm_illegal (imm_illegal)
  );

  rv32i_imm_gen #(.XLEN(32), .ZEXT_SHAMT(0)) dut_nz (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .imm         (imm_nz),
    .imm_valid   (imm_valid_nz),
    .imm_fmt     (imm_fmt_nz),
    .imm_illegal (imm_illegal_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one valid instruction, then check the registered result after the edge
  task automatic send(input string name, input logic [31:0] word, input logic [31:0] exp_imm,
                      input logic [2:0] exp_fmt, input logic exp_ill);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = word;
    @(posedge clk);
    #1;
    $display("[TB] %s instr=0x%08h imm=0x%08h fmt=%0d ill=%0b vld=%0b",
             name, word, imm, imm_fmt, imm_illegal, imm_valid);
    check({name, ".imm"}, imm, exp_imm);
    check({name, ".fmt"}, {29'b0, imm_fmt}, {29'b0, exp_fmt});
    check({name, ".ill"}, {31'b0, imm_illegal}, {31'b0, exp_ill});
    check({name, ".vld"}, {31'b0, imm_valid}, 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    instr_valid  = 1'b0;
    instr        = 32'b0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("[TB] reset imm=0x%08h fmt=%0d ill=%0b vld=%0b", imm, imm_fmt, imm_illegal, imm_valid);
    check("rst.imm", imm, 32'h0);
    check("rst.fmt", {29'b0, imm_fmt}, 32'h0);
    check("rst.ill", {31'b0, imm_illegal}, 32'h0);
    check("rst.vld", {31'b0, imm_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Positive I/S/U, back-to-back
    send("addi10", 32'h00A10093, 32'h0000000A, 3'd1, 1'b0);
    send("lw8",    32'h00812083, 32'h00000008, 3'd1, 1'b0);
    send("sw12",   32'h00112623, 32'h0000000C, 3'd2, 1'b0);
    send("lui",    32'h000120B7, 32'h00012000, 3'd4, 1'b0);
    // Branch / jump
    send("beq16",  32'h00208863, 32'h00000010, 3'd3, 1'b0);
    send("jal32",  32'h020000EF, 32'h00000020, 3'd5, 1'b0);
    send("beqm4",  32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0);
    // Sign extension extremes
    send("addim1", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
    send("addimx", 32'h7FF00093, 32'h000007FF, 3'd1, 1'b0);
    send("addimn", 32'h80000093, 32'hFFFFF800, 3'd1, 1'b0);
    // LH with funct3=001 is not a shift: sign-extended offset -1
    send("lhm1",   32'hFFF11083, 32'hFFFFFFFF, 3'd1, 1'b0);
    // SRAI: zero-extended shamt vs plain sign extension
    send("srai3",  32'h4030D093, 32'h00000003, 3'd1, 1'b0);
    check("srai3.nz.imm", imm_nz, 32'h00000403);
    check("srai3.nz.fmt", {29'b0, imm_fmt_nz}, 32'd1);
    // AUIPC with negative upper immediate
    send("auipc",  32'hFFFFF097, 32'hFFFFF000, 3'd4, 1'b0);
    // R type and illegal words
    send("add",    32'h002081B3, 32'h00000000, 3'd0, 1'b0);
    send("ill7f",  32'h0000007F, 32'h00000000, 3'd0, 1'b1);
    send("ill00",  32'h00000000, 32'h00000000, 3'd0, 1'b1);
    send("sw12b",  32'h00112623, 32'h0000000C, 3'd2, 1'b0);

    // Gap: valid drops, results hold
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 32'hFFF00093;
    @(posedge clk);
    #1;
    $display("[TB] gap imm=0x%08h fmt=%0d vld=%0b", imm, imm_fmt, imm_valid);
    check("gap.vld", {31'b0, imm_valid}, 32'h0);
    check("gap.imm", imm, 32'h0000000C);
    check("gap.fmt", {29'b0, imm_fmt}, 32'd2);

    // Reset mid-stream with a valid instruction present
    @(negedge clk);
    rst         = 1'b1;
    instr_valid = 1'b1;
    instr       = 32'hFFF00093;
    @(posedge clk);
    #1;
    $display("[TB] midrst imm=0x%08h fmt=%0d ill=%0b vld=%0b", imm, imm_fmt, imm_illegal, imm_valid);
    check("midrst.imm", imm, 32'h0);
    check("midrst.fmt", {29'b0, imm_fmt}, 32'h0);
    check("midrst.vld", {31'b0, imm_valid}, 32'h0);
    @(negedge clk);
    rst         = 1'b0;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] postrst imm=0x%08h vld=%0b", imm, imm_valid);
    check("postrst.vld", {31'b0, imm_valid}, 32'h0);
    check("postrst.imm", imm, 32'h0);

    // Resumes cleanly after reset
    send("jal32b", 32'h020000EF, 32'h00000020, 3'd5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
